// File: rtl/add_rs_param.sv
// Integer add/sub reservation station: DEPTH entries snoop the CDB, the oldest
// ready entry feeds one ALU stage whose result is held until the CDB grant.
module add_rs_param #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int TAG_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_flush,
    input  logic              in_issue_valid,
    output logic              out_issue_ready,
    output logic [TAG_W-1:0]  out_issue_tag,
    input  logic [5:0]        in_operator_type,
    input  logic [DATA_W-1:0] in_val_1,
    input  logic [DATA_W-1:0] in_val_2,
    input  logic [TAG_W-1:0]  in_tag_1,
    input  logic [TAG_W-1:0]  in_tag_2,
    input  logic [3:0]        in_icc_flags,
    input  logic [TAG_W-1:0]  in_icc_tag,
    input  logic              in_cdb_valid,
    input  logic [TAG_W-1:0]  in_cdb_tag,
    input  logic [DATA_W-1:0] in_cdb_val,
    input  logic              in_cdb_icc_valid,
    input  logic [3:0]        in_cdb_icc,
    output logic              out_cdb_req,
    input  logic              in_cdb_grant,
    output logic [TAG_W-1:0]  out_cdb_tag,
    output logic [DATA_W-1:0] out_cdb_val,
    output logic              out_cdb_icc_valid,
    output logic [3:0]        out_cdb_icc
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TAG_W-1:0] TAG_INV = {TAG_W{1'b1}};
    localparam logic [IW-1:0]    AGE_MAX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } st_e;

    // op is kept as {cc, x, sub}; the other op3 bits are constant for supported ops
    st_e               st_q  [DEPTH];
    st_e               st_d  [DEPTH];
    logic [2:0]        op_q  [DEPTH];
    logic [2:0]        op_d  [DEPTH];
    logic [DATA_W-1:0] v1_q  [DEPTH];
    logic [DATA_W-1:0] v1_d  [DEPTH];
    logic [DATA_W-1:0] v2_q  [DEPTH];
    logic [DATA_W-1:0] v2_d  [DEPTH];
    logic [TAG_W-1:0]  t1_q  [DEPTH];
    logic [TAG_W-1:0]  t1_d  [DEPTH];
    logic [TAG_W-1:0]  t2_q  [DEPTH];
    logic [TAG_W-1:0]  t2_d  [DEPTH];
    logic [TAG_W-1:0]  ct_q  [DEPTH];
    logic [TAG_W-1:0]  ct_d  [DEPTH];
    logic              c_q   [DEPTH];
    logic              c_d   [DEPTH];
    logic [IW-1:0]     age_q [DEPTH];
    logic [IW-1:0]     age_d [DEPTH];

    logic              stg_vld_q;
    logic [IW-1:0]     stg_idx_q;
    logic [TAG_W-1:0]  stg_tag_q;
    logic [DATA_W-1:0] stg_val_q;
    logic              stg_iccv_q;
    logic [3:0]        stg_icc_q;

    logic              free_found_s;
    logic [IW-1:0]     free_idx_s;
    logic              sel_found_s;
    logic [IW-1:0]     sel_idx_s;
    logic [IW-1:0]     sel_age_s;
    logic              op_ok_s;
    logic              accept_s;
    logic              grant_s;
    logic              dispatch_s;
    logic [DATA_W+3:0] alu_s;
    logic [DATA_W-1:0] new_v1_s;
    logic [DATA_W-1:0] new_v2_s;
    logic [TAG_W-1:0]  new_t1_s;
    logic [TAG_W-1:0]  new_t2_s;
    logic [TAG_W-1:0]  new_ct_s;
    logic              new_c_s;
    logic              unused_icc_s;

    function automatic logic op_ok_f(input logic [5:0] op);
        return (op[5] == 1'b0) && (op[1:0] == 2'b00);
    endfunction

    // The INVALID tag never matches, even if something broadcasts it
    function automatic logic hit_f(input logic vld, input logic [TAG_W-1:0] bus_tag,
                                   input logic [TAG_W-1:0] tag);
        return vld && (tag == bus_tag) && (tag != TAG_INV);
    endfunction

    // Returns {N,Z,V,C, result}; borrow shows up as the extra top bit on subtract
    function automatic logic [DATA_W+3:0] alu_f(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b, input logic cin);
        logic [DATA_W:0] r;
        logic [DATA_W:0] ci;
        logic            n;
        logic            z;
        logic            v;
        ci = {{DATA_W{1'b0}}, op[1] & cin};
        if (op[0]) begin
            r = {1'b0, a} - {1'b0, b} - ci;
            v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
        end else begin
            r = {1'b0, a} + {1'b0, b} + ci;
            v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
        end
        n = r[DATA_W-1];
        z = (r[DATA_W-1:0] == {DATA_W{1'b0}});
        return {n, z, v, r[DATA_W], r[DATA_W-1:0]};
    endfunction

    assign unused_icc_s = ^{in_icc_flags[3:1], in_cdb_icc[3:1]};

    // Lowest-index free entry
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = {IW{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (st_q[i] == ST_FREE) begin
                free_found_s = 1'b1;
                free_idx_s   = IW'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Oldest ready entry; strict compare keeps the lowest index on ties
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {IW{1'b0}};
        sel_age_s   = {IW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if ((st_q[i] == ST_READY) && (!sel_found_s || (age_q[i] > sel_age_s))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IW'(i);
                sel_age_s   = age_q[i];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    assign op_ok_s         = op_ok_f(in_operator_type);
    assign accept_s        = in_issue_valid && free_found_s && op_ok_s && !in_flush;
    assign grant_s         = stg_vld_q && in_cdb_grant;
    assign dispatch_s      = sel_found_s && (!stg_vld_q || in_cdb_grant) && !in_flush;
    assign alu_s           = alu_f(op_q[sel_idx_s], v1_q[sel_idx_s], v2_q[sel_idx_s], c_q[sel_idx_s]);
    assign out_issue_ready = free_found_s;
    assign out_issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx_s);

    // Operands of the incoming op after the issue-time CDB bypass
    always_comb begin
        new_v1_s = in_val_1;
        new_t1_s = in_tag_1;
        new_v2_s = in_val_2;
        new_t2_s = in_tag_2;
        new_c_s  = 1'b0;
        new_ct_s = TAG_INV;
        if (hit_f(in_cdb_valid, in_cdb_tag, in_tag_1)) begin
            new_v1_s = in_cdb_val;
            new_t1_s = TAG_INV;
        end else begin
            new_v1_s = in_val_1;
        end
        if (hit_f(in_cdb_valid, in_cdb_tag, in_tag_2)) begin
            new_v2_s = in_cdb_val;
            new_t2_s = TAG_INV;
        end else begin
            new_v2_s = in_val_2;
        end
        if (!in_operator_type[3]) begin
            new_ct_s = TAG_INV;
        end else if (hit_f(in_cdb_icc_valid, in_cdb_tag, in_icc_tag)) begin
            new_c_s  = in_cdb_icc[0];
            new_ct_s = TAG_INV;
        end else begin
            new_c_s  = in_icc_flags[0];
            new_ct_s = in_icc_tag;
        end
    end

    // Per-entry next state: snoop, dispatch, grant release, capture, aging
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i]  = st_q[i];
            op_d[i]  = op_q[i];
            v1_d[i]  = v1_q[i];
            v2_d[i]  = v2_q[i];
            t1_d[i]  = t1_q[i];
            t2_d[i]  = t2_q[i];
            ct_d[i]  = ct_q[i];
            c_d[i]   = c_q[i];
            age_d[i] = age_q[i];
            if (in_flush) begin
                st_d[i]  = ST_FREE;
                age_d[i] = {IW{1'b0}};
            end else begin
                if (accept_s && (st_q[i] != ST_FREE) && (age_q[i] != AGE_MAX)) begin
                    age_d[i] = age_q[i] + {{(IW-1){1'b0}}, 1'b1};
                end else begin
                    age_d[i] = age_q[i];
                end
                if (st_q[i] == ST_WAIT) begin
                    if (hit_f(in_cdb_valid, in_cdb_tag, t1_q[i])) begin
                        v1_d[i] = in_cdb_val;
                        t1_d[i] = TAG_INV;
                    end else begin
                        t1_d[i] = t1_q[i];
                    end
                    if (hit_f(in_cdb_valid, in_cdb_tag, t2_q[i])) begin
                        v2_d[i] = in_cdb_val;
                        t2_d[i] = TAG_INV;
                    end else begin
                        t2_d[i] = t2_q[i];
                    end
                    if (hit_f(in_cdb_icc_valid, in_cdb_tag, ct_q[i])) begin
                        c_d[i]  = in_cdb_icc[0];
                        ct_d[i] = TAG_INV;
                    end else begin
                        ct_d[i] = ct_q[i];
                    end
                    if ((t1_d[i] == TAG_INV) && (t2_d[i] == TAG_INV) && (ct_d[i] == TAG_INV)) begin
                        st_d[i] = ST_READY;
                    end else begin
                        st_d[i] = ST_WAIT;
                    end
                end else if (dispatch_s && (sel_idx_s == IW'(i))) begin
                    st_d[i] = ST_EXEC;
                end else if (grant_s && (stg_idx_q == IW'(i))) begin
                    st_d[i]  = ST_FREE;
                    age_d[i] = {IW{1'b0}};
                end else if (accept_s && (free_idx_s == IW'(i))) begin
                    op_d[i]  = {in_operator_type[4], in_operator_type[3], in_operator_type[2]};
                    v1_d[i]  = new_v1_s;
                    v2_d[i]  = new_v2_s;
                    t1_d[i]  = new_t1_s;
                    t2_d[i]  = new_t2_s;
                    ct_d[i]  = new_ct_s;
                    c_d[i]   = new_c_s;
                    age_d[i] = {IW{1'b0}};
                    if ((new_t1_s == TAG_INV) && (new_t2_s == TAG_INV) && (new_ct_s == TAG_INV)) begin
                        st_d[i] = ST_READY;
                    end else begin
                        st_d[i] = ST_WAIT;
                    end
                end else begin
                    st_d[i] = st_q[i];
                end
            end
        end
    end

    // Entry state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]  <= ST_FREE;
                op_q[i]  <= 3'b000;
                v1_q[i]  <= {DATA_W{1'b0}};
                v2_q[i]  <= {DATA_W{1'b0}};
                t1_q[i]  <= TAG_INV;
                t2_q[i]  <= TAG_INV;
                ct_q[i]  <= TAG_INV;
                c_q[i]   <= 1'b0;
                age_q[i] <= {IW{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]  <= st_d[i];
                op_q[i]  <= op_d[i];
                v1_q[i]  <= v1_d[i];
                v2_q[i]  <= v2_d[i];
                t1_q[i]  <= t1_d[i];
                t2_q[i]  <= t2_d[i];
                ct_q[i]  <= ct_d[i];
                c_q[i]   <= c_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    // ALU result stage, held until granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld_q  <= 1'b0;
            stg_idx_q  <= {IW{1'b0}};
            stg_tag_q  <= {TAG_W{1'b0}};
            stg_val_q  <= {DATA_W{1'b0}};
            stg_iccv_q <= 1'b0;
            stg_icc_q  <= 4'b0000;
        end else if (in_flush || (grant_s && !dispatch_s)) begin
            stg_vld_q  <= 1'b0;
            stg_idx_q  <= {IW{1'b0}};
            stg_tag_q  <= {TAG_W{1'b0}};
            stg_val_q  <= {DATA_W{1'b0}};
            stg_iccv_q <= 1'b0;
            stg_icc_q  <= 4'b0000;
        end else if (dispatch_s) begin
            stg_vld_q  <= 1'b1;
            stg_idx_q  <= sel_idx_s;
            stg_tag_q  <= TAG_W'(TAG_BASE) + TAG_W'(sel_idx_s);
            stg_val_q  <= alu_s[DATA_W-1:0];
            stg_iccv_q <= op_q[sel_idx_s][2];
            stg_icc_q  <= op_q[sel_idx_s][2] ? alu_s[DATA_W+3:DATA_W] : 4'b0000;
        end else begin
            stg_vld_q  <= stg_vld_q;
        end
    end

    assign out_cdb_req       = stg_vld_q;
    assign out_cdb_tag       = stg_tag_q;
    assign out_cdb_val       = stg_val_q;
    assign out_cdb_icc_valid = stg_iccv_q;
    assign out_cdb_icc       = stg_icc_q;

endmodule

// File: tb/tb_add_rs_param.sv
// Directed bench for add_rs_param: a table of single-op vectors plus
// hand-written sequences for wake-up, ordering, back-pressure, flush and reset.
module tb_add_rs_param;

    localparam logic [4:0] INV = 5'h1F;

    logic        clk;
    logic        rst;
    logic        in_flush;
    logic        in_issue_valid;
    logic        out_issue_ready;
    logic [4:0]  out_issue_tag;
    logic [5:0]  in_operator_type;
    logic [31:0] in_val_1;
    logic [31:0] in_val_2;
    logic [4:0]  in_tag_1;
    logic [4:0]  in_tag_2;
    logic [3:0]  in_icc_flags;
    logic [4:0]  in_icc_tag;
    logic        in_cdb_valid;
    logic [4:0]  in_cdb_tag;
    logic [31:0] in_cdb_val;
    logic        in_cdb_icc_valid;
    logic [3:0]  in_cdb_icc;
    logic        out_cdb_req;
    logic        in_cdb_grant;
    logic [4:0]  out_cdb_tag;
    logic [31:0] out_cdb_val;
    logic        out_cdb_icc_valid;
    logic [3:0]  out_cdb_icc;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] val;
        logic        iccv;
        logic [3:0]  icc;
    } vec_t;

    vec_t vecs [10];

    add_rs_param #(.DEPTH(4), .DATA_W(32), .TAG_W(5), .TAG_BASE(0)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_flush          (in_flush),
        .in_issue_valid    (in_issue_valid),
        .out_issue_ready   (out_issue_ready),
        .out_issue_tag     (out_issue_tag),
        .in_operator_type  (in_operator_type),
        .in_val_1          (in_val_1),
        .in_val_2          (in_val_2),
        .in_tag_1          (in_tag_1),
        .in_tag_2          (in_tag_2),
        .in_icc_flags      (in_icc_flags),
        .in_icc_tag        (in_icc_tag),
        .in_cdb_valid      (in_cdb_valid),
        .in_cdb_tag        (in_cdb_tag),
        .in_cdb_val        (in_cdb_val),
        .in_cdb_icc_valid  (in_cdb_icc_valid),
        .in_cdb_icc        (in_cdb_icc),
        .out_cdb_req       (out_cdb_req),
        .in_cdb_grant      (in_cdb_grant),
        .out_cdb_tag       (out_cdb_tag),
        .out_cdb_val       (out_cdb_val),
        .out_cdb_icc_valid (out_cdb_icc_valid),
        .out_cdb_icc       (out_cdb_icc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_flush         = 1'b0;
        in_issue_valid   = 1'b0;
        in_operator_type = 6'b000000;
        in_val_1         = 32'd0;
        in_val_2         = 32'd0;
        in_tag_1         = INV;
        in_tag_2         = INV;
        in_icc_flags     = 4'b0000;
        in_icc_tag       = INV;
        in_cdb_valid     = 1'b0;
        in_cdb_tag       = 5'd0;
        in_cdb_val       = 32'd0;
        in_cdb_icc_valid = 1'b0;
        in_cdb_icc       = 4'b0000;
        in_cdb_grant     = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t1, input logic [4:0] t2, input logic [3:0] flags,
                         input logic [4:0] ct);
        in_issue_valid   = 1'b1;
        in_operator_type = op;
        in_val_1         = a;
        in_val_2         = b;
        in_tag_1         = t1;
        in_tag_2         = t2;
        in_icc_flags     = flags;
        in_icc_tag       = ct;
    endtask

    task automatic bcast(input logic [4:0] tag, input logic [31:0] val);
        in_cdb_valid = 1'b1;
        in_cdb_tag   = tag;
        in_cdb_val   = val;
    endtask

    task automatic check_res(input string name, input logic [4:0] tag, input logic [31:0] val);
        chk({name, "_req"}, 64'(out_cdb_req), 64'(1'b1));
        chk({name, "_tag"}, 64'(out_cdb_tag), 64'(tag));
        chk({name, "_val"}, 64'(out_cdb_val), 64'(val));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        //            op          a             b             cin   val           iccv  icc
        vecs[0] = '{6'b000000, 32'd5,        32'd7,        1'b0, 32'd12,       1'b0, 4'b0000};
        vecs[1] = '{6'b010100, 32'd3,        32'd5,        1'b0, 32'hFFFFFFFE, 1'b1, 4'b1001};
        vecs[2] = '{6'b010000, 32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b1, 4'b1010};
        vecs[3] = '{6'b011000, 32'hFFFFFFFF, 32'd0,        1'b1, 32'd0,        1'b1, 4'b0101};
        vecs[4] = '{6'b001100, 32'd10,       32'd3,        1'b1, 32'd6,        1'b0, 4'b0000};
        vecs[5] = '{6'b011100, 32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b1, 4'b0010};
        vecs[6] = '{6'b010100, 32'd5,        32'd5,        1'b0, 32'd0,        1'b1, 4'b0100};
        vecs[7] = '{6'b010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 4'b1001};
        vecs[8] = '{6'b001000, 32'd1,        32'd1,        1'b1, 32'd3,        1'b0, 4'b0000};
        vecs[9] = '{6'b000000, 32'd1,        32'd1,        1'b1, 32'd2,        1'b0, 4'b0000};

        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_req", 64'(out_cdb_req), 64'(1'b0));
        chk("rst_cdb_tag", 64'(out_cdb_tag), 64'(5'd0));
        chk("rst_cdb_val", 64'(out_cdb_val), 64'(32'd0));
        chk("rst_icc", 64'({out_cdb_icc_valid, out_cdb_icc}), 64'(5'd0));
        chk("rst_ready", 64'(out_issue_ready), 64'(1'b1));
        chk("rst_itag", 64'(out_issue_tag), 64'(5'd0));

        // Single ops through an idle station: accept, dispatch, result, grant
        for (int k = 0; k < 10; k++) begin
            chk("vec_itag0", 64'(out_issue_tag), 64'(5'd0));
            issue(vecs[k].op, vecs[k].a, vecs[k].b, INV, INV, {3'b000, vecs[k].cin}, INV);
            tick();
            idle();
            chk("vec_req_e0", 64'(out_cdb_req), 64'(1'b0));
            chk("vec_itag_e0", 64'(out_issue_tag), 64'(5'd1));
            tick();
            check_res("vec", 5'd0, vecs[k].val);
            chk("vec_iccv", 64'(out_cdb_icc_valid), 64'(vecs[k].iccv));
            chk("vec_icc", 64'(out_cdb_icc), 64'(vecs[k].icc));
            in_cdb_grant = 1'b1;
            tick();
            in_cdb_grant = 1'b0;
            chk("vec_req_after_grant", 64'(out_cdb_req), 64'(1'b0));
            chk("vec_itag_freed", 64'(out_issue_tag), 64'(5'd0));
        end

        // Unsupported op is never accepted
        issue(6'b000001, 32'd1, 32'd1, INV, INV, 4'b0000, INV);
        tick();
        idle();
        chk("unsup_itag", 64'(out_issue_tag), 64'(5'd0));
        tick();
        chk("unsup_req", 64'(out_cdb_req), 64'(1'b0));

        // Issue-time bypass of operand 1
        issue(6'b000000, 32'd0, 32'd1, 5'd7, INV, 4'b0000, INV);
        bcast(5'd7, 32'd100);
        tick();
        idle();
        tick();
        check_res("bypass", 5'd0, 32'd101);
        in_cdb_grant = 1'b1;
        tick();
        idle();

        // ADDX waiting on operand 1 and ICC from producer 2
        issue(6'b001000, 32'd0, 32'd4, 5'd2, INV, 4'b0000, 5'd2);
        tick();
        idle();
        tick();
        tick();
        chk("addx_wait_req", 64'(out_cdb_req), 64'(1'b0));
        bcast(5'd2, 32'd10);
        in_cdb_icc_valid = 1'b1;
        in_cdb_icc       = 4'b0001;
        tick();
        idle();
        chk("addx_wake_req", 64'(out_cdb_req), 64'(1'b0));
        tick();
        check_res("addx", 5'd0, 32'd15);
        chk("addx_iccv", 64'(out_cdb_icc_valid), 64'(1'b0));
        in_cdb_grant = 1'b1;
        tick();
        idle();

        // Fill all four entries with waiting ops (entries 0 and 2 share tag 20)
        for (int i = 0; i < 4; i++) begin
            logic [4:0] wt [4];
            wt[0] = 5'd20;
            wt[1] = 5'd21;
            wt[2] = 5'd20;
            wt[3] = 5'd23;
            chk("fill_itag", 64'(out_issue_tag), 64'(i));
            issue(6'b000000, 32'd0, 32'(i), wt[i], INV, 4'b0000, INV);
            tick();
        end
        idle();
        chk("full_ready", 64'(out_issue_ready), 64'(1'b0));
        issue(6'b000000, 32'd9, 32'd9, INV, INV, 4'b0000, INV);
        tick();
        idle();
        chk("full_ready_after5th", 64'(out_issue_ready), 64'(1'b0));
        tick();
        chk("full_no_req", 64'(out_cdb_req), 64'(1'b0));

        // Wake 3 then 1, and hold the grant off with 1 ready behind 3
        bcast(5'd23, 32'd100);
        tick();
        bcast(5'd21, 32'd200);
        tick();
        idle();
        check_res("wake3", 5'd3, 32'd103);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_res("hold", 5'd3, 32'd103);
        end
        in_cdb_grant = 1'b1;
        tick();
        idle();
        check_res("wake1", 5'd1, 32'd201);

        // Entries 0 and 2 wake together; the older entry 0 goes first
        in_cdb_grant = 1'b1;
        bcast(5'd20, 32'd50);
        tick();
        idle();
        chk("tie_gap_req", 64'(out_cdb_req), 64'(1'b0));
        tick();
        check_res("oldest0", 5'd0, 32'd50);
        in_cdb_grant = 1'b1;
        tick();
        idle();
        check_res("then2", 5'd2, 32'd52);
        in_cdb_grant = 1'b1;
        tick();
        idle();
        chk("drain_req", 64'(out_cdb_req), 64'(1'b0));
        chk("drain_itag", 64'(out_issue_tag), 64'(5'd0));

        // Flush with a pending result and three busy entries; flush beats issue
        for (int pass = 0; pass < 2; pass++) begin
            issue(6'b000000, 32'd1, 32'd2, INV, INV, 4'b0000, INV);
            tick();
            issue(6'b000000, 32'd0, 32'd0, 5'd25, INV, 4'b0000, INV);
            tick();
            issue(6'b000000, 32'd0, 32'd0, 5'd26, INV, 4'b0000, INV);
            tick();
            idle();
            check_res("pre_squash", 5'd0, 32'd3);
            chk("pre_squash_itag", 64'(out_issue_tag), 64'(5'd3));
            if (pass == 0) begin
                in_flush = 1'b1;
                issue(6'b000000, 32'd1, 32'd1, INV, INV, 4'b0000, INV);
                in_cdb_grant = 1'b1;
                tick();
                idle();
            end else begin
                rst = 1'b1;
                #2;
                chk("rst_async_req", 64'(out_cdb_req), 64'(1'b0));
                tick();
                rst = 1'b0;
            end
            chk("squash_req", 64'(out_cdb_req), 64'(1'b0));
            chk("squash_ready", 64'(out_issue_ready), 64'(1'b1));
            chk("squash_itag", 64'(out_issue_tag), 64'(5'd0));
            bcast(5'd25, 32'd7);
            tick();
            idle();
            tick();
            tick();
            chk("squash_stays_empty", 64'(out_cdb_req), 64'(1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
